axil_processor_bridge: RTL and testbench

AXI4-Lite slave that sits directly upstream of `top_processor` and turns host bus transactions into its native memory-load, op-load, start and result-readback strobes. Software loads operand memories A/B and the op memory, kicks a run, polls status and reads back results without driving the raw ports. One transaction is in flight at a time. Every processor-side output is registered.

---
 rtl/axil_processor_bridge_pkg.sv | 33 +++
 rtl/axil_region_decode.sv | 55 +++++
 rtl/axil_processor_bridge.sv | 228 ++++++++++++++++++++++
 tb/tb_axil_processor_bridge.sv | 546 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_processor_bridge_pkg.sv
// Shared widths, region codes and response codes
// for the AXI4-Lite to processor bridge.
package axil_processor_bridge_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;
  localparam int OP_WIDTH   = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    RGN_NONE,
    REG_CTRL,
    REG_STATUS,
    RGN_A,
    RGN_B,
    RGN_RES,
    RGN_OP
  } region_t;

  typedef enum logic [2:0] {
    IDLE,
    W_ACC,
    W_EXEC,
    W_RESP,
    R_ACC,
    R_MEM,
    R_WAIT,
    R_RESP
  } state_t;

endpackage

// File: rtl/axil_region_decode.sv
// Maps a bus address and access kind onto a
// bridge region, a word index and a legality flag.
module axil_region_decode
  import axil_processor_bridge_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [AW-1:0]         addr,
  input  logic                  wr,
  output region_t               region,
  output logic [ADDR_WIDTH-1:0] index,
  output logic                  legal
);

  logic [3:0]  rgn;
  logic [11:0] off;

  assign rgn = addr[15:12];
  assign off = addr[11:0];

  // A/B/op are write-only, STATUS is read-only
  always_comb begin
    region = RGN_NONE;
    legal  = 1'b0;
    index  = addr[ADDR_WIDTH+1:2];
    unique case (1'b1)
      (rgn == 4'h0) && (off == 12'h000): begin
        region = REG_CTRL;
        legal  = 1'b1;
      end
      (rgn == 4'h0) && (off == 12'h004): begin
        region = REG_STATUS;
        legal  = !wr;
      end
      (rgn == 4'h1): begin
        region = RGN_A;
        legal  = wr;
      end
      (rgn == 4'h2): begin
        region = RGN_B;
        legal  = wr;
      end
      (rgn == 4'h3): begin
        region = RGN_RES;
        legal  = 1'b1;
      end
      (rgn == 4'h4): begin
        region = RGN_OP;
        legal  = wr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/axil_processor_bridge.sv
// AXI4-Lite slave driving processor memory loads,
// op loads, run start and result readback.
module axil_processor_bridge
  import axil_processor_bridge_pkg::*;
#(
  parameter int S_AXI_ADDR_WIDTH = 16,
  parameter int S_AXI_DATA_WIDTH = 32
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [ADDR_WIDTH-1:0]         addr_data_o,
  output logic                          ena_data_a_o,
  output logic                          wea_data_a_o,
  output logic                          ena_data_b_o,
  output logic                          wea_data_b_o,
  output logic                          ena_data_result_o,
  output logic                          wea_data_result_o,
  input  logic [DATA_WIDTH-1:0]         data_i,
  output logic [OP_WIDTH-1:0]           op_o,
  output logic [ADDR_WIDTH-1:0]         addr_op_o,
  output logic                          ena_op_o,
  output logic                          wea_op_o,
  output logic                          start_o,
  input  logic                          done_i
);

  state_t                        state;
  logic [S_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [S_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [S_AXI_DATA_WIDTH/8-1:0] strb_q;
  logic                          done;
  logic                          last_rd;

  region_t               region;
  logic [ADDR_WIDTH-1:0] index;
  logic                  legal;
  logic                  is_mem;
  logic                  wr_req;
  logic                  rd_req;

  assign wr_req = s_axi_awvalid && s_axi_wvalid;
  assign rd_req = s_axi_arvalid;
  assign is_mem = region inside {RGN_A, RGN_B, RGN_RES, RGN_OP};

  axil_region_decode #(
    .AW(S_AXI_ADDR_WIDTH)
  ) u_decode (
    .addr  (addr_q),
    .wr    (state == W_ACC),
    .region(region),
    .index (index),
    .legal (legal)
  );

  // Transaction FSM, run/done flags and all registered outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state             <= IDLE;
      addr_q            <= '0;
      wdata_q           <= '0;
      strb_q            <= '0;
      done              <= 1'b0;
      last_rd           <= 1'b1;
      s_axi_awready     <= 1'b0;
      s_axi_wready      <= 1'b0;
      s_axi_bresp       <= RESP_OKAY;
      s_axi_bvalid      <= 1'b0;
      s_axi_arready     <= 1'b0;
      s_axi_rdata       <= '0;
      s_axi_rresp       <= RESP_OKAY;
      s_axi_rvalid      <= 1'b0;
      data_o            <= '0;
      addr_data_o       <= '0;
      ena_data_a_o      <= 1'b0;
      wea_data_a_o      <= 1'b0;
      ena_data_b_o      <= 1'b0;
      wea_data_b_o      <= 1'b0;
      ena_data_result_o <= 1'b0;
      wea_data_result_o <= 1'b0;
      op_o              <= '0;
      addr_op_o         <= '0;
      ena_op_o          <= 1'b0;
      wea_op_o          <= 1'b0;
      start_o           <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_req && (!rd_req || last_rd)) begin
            addr_q        <= s_axi_awaddr;
            wdata_q       <= s_axi_wdata;
            strb_q        <= s_axi_wstrb;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            last_rd       <= 1'b0;
            state         <= W_ACC;
          end else if (rd_req) begin
            addr_q        <= s_axi_araddr;
            s_axi_arready <= 1'b1;
            last_rd       <= 1'b1;
            state         <= R_ACC;
          end
        end
        W_ACC: begin
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b0;
          s_axi_bresp   <= RESP_OKAY;
          state         <= W_EXEC;
          if (!legal ||
              (is_mem && ((strb_q != '1) || start_o))) begin
            s_axi_bresp <= RESP_SLVERR;
          end else begin
            case (region)
              REG_CTRL: begin
                if (wdata_q[0] && !start_o) begin
                  start_o <= 1'b1;
                  done    <= 1'b0;
                end
                if (wdata_q[1]) done <= 1'b0;
              end
              RGN_A: begin
                ena_data_a_o <= 1'b1;
                wea_data_a_o <= 1'b1;
                addr_data_o  <= index;
                data_o       <= wdata_q[DATA_WIDTH-1:0];
              end
              RGN_B: begin
                ena_data_b_o <= 1'b1;
                wea_data_b_o <= 1'b1;
                addr_data_o  <= index;
                data_o       <= wdata_q[DATA_WIDTH-1:0];
              end
              RGN_RES: begin
                ena_data_result_o <= 1'b1;
                wea_data_result_o <= 1'b1;
                addr_data_o       <= index;
                data_o            <= wdata_q[DATA_WIDTH-1:0];
              end
              RGN_OP: begin
                ena_op_o  <= 1'b1;
                wea_op_o  <= 1'b1;
                addr_op_o <= index;
                op_o      <= wdata_q[OP_WIDTH-1:0];
              end
              default: ;
            endcase
          end
        end
        W_EXEC: begin
          ena_data_a_o      <= 1'b0;
          wea_data_a_o      <= 1'b0;
          ena_data_b_o      <= 1'b0;
          wea_data_b_o      <= 1'b0;
          ena_data_result_o <= 1'b0;
          wea_data_result_o <= 1'b0;
          ena_op_o          <= 1'b0;
          wea_op_o          <= 1'b0;
          s_axi_bvalid      <= 1'b1;
          state             <= W_RESP;
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= IDLE;
          end
        end
        R_ACC: begin
          s_axi_arready <= 1'b0;
          if (!legal || ((region == RGN_RES) && start_o)) begin
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_SLVERR;
            s_axi_rvalid <= 1'b1;
            state        <= R_RESP;
          end else if (region == RGN_RES) begin
            ena_data_result_o <= 1'b1;
            wea_data_result_o <= 1'b0;
            addr_data_o       <= index;
            state             <= R_MEM;
          end else begin
            s_axi_rdata  <= S_AXI_DATA_WIDTH'({done, start_o});
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b1;
            state        <= R_RESP;
          end
        end
        R_MEM: begin
          ena_data_result_o <= 1'b0;
          state             <= R_WAIT;
        end
        R_WAIT: begin
          s_axi_rdata  <= S_AXI_DATA_WIDTH'(data_i);
          s_axi_rresp  <= RESP_OKAY;
          s_axi_rvalid <= 1'b1;
          state        <= R_RESP;
        end
        R_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (start_o && done_i) begin
        start_o <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axil_processor_bridge.sv
// Directed self-checking bench for the AXI4-Lite
// processor bridge with a small result-memory model.
module tb_axil_processor_bridge;
  import axil_processor_bridge_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [15:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] data_o;
  logic [9:0]  addr_data_o;
  logic        ena_data_a_o, wea_data_a_o;
  logic        ena_data_b_o, wea_data_b_o;
  logic        ena_data_result_o, wea_data_result_o;
  logic [31:0] data_i;
  logic [7:0]  op_o;
  logic [9:0]  addr_op_o;
  logic        ena_op_o, wea_op_o;
  logic        start_o;
  logic        done_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  cap_en;
  logic [9:0]  cap_addr;
  logic [31:0] cap_data;
  logic [7:0]  cap_op;
  logic [9:0]  cap_aop;

  logic [31:0] res_mem [0:1023];

  wire [7:0] en_vec = {ena_data_a_o, wea_data_a_o,
                       ena_data_b_o, wea_data_b_o,
                       ena_data_result_o, wea_data_result_o,
                       ena_op_o, wea_op_o};

  axil_processor_bridge dut (
    .CLK(clk), .RST(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .data_o(data_o), .addr_data_o(addr_data_o),
    .ena_data_a_o(ena_data_a_o), .wea_data_a_o(wea_data_a_o),
    .ena_data_b_o(ena_data_b_o), .wea_data_b_o(wea_data_b_o),
    .ena_data_result_o(ena_data_result_o),
    .wea_data_result_o(wea_data_result_o),
    .data_i(data_i),
    .op_o(op_o), .addr_op_o(addr_op_o),
    .ena_op_o(ena_op_o), .wea_op_o(wea_op_o),
    .start_o(start_o), .done_i(done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) res_mem[5] <= 32'h0000ABCD;
    else if (ena_data_result_o) begin
      if (wea_data_result_o) res_mem[addr_data_o] <= data_o;
      else data_i <= res_mem[addr_data_o];
    end
  end

  task automatic axi_write(
    input  logic [15:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    output logic [1:0]  resp,
    output int rdy_k, output int rdy_n,
    output int en_k, output int en_n,
    output int bv_k);
    rdy_k = -1; rdy_n = 0; en_k = -1; en_n = 0; bv_k = -1;
    resp = 2'b11;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bready) begin
        bready = 1'b0;
        break;
      end
      if (rdy_k >= 0) begin
        awvalid = 1'b0;
        wvalid  = 1'b0;
      end
      if (awready && wready) begin
        rdy_n++;
        if (rdy_k < 0) rdy_k = k;
      end
      if (en_vec != 8'h00) begin
        en_n++;
        if (en_k < 0) begin
          en_k = k; cap_en = en_vec;
          cap_addr = addr_data_o; cap_data = data_o;
          cap_op = op_o; cap_aop = addr_op_o;
        end
      end
      if (bvalid && bv_k < 0) begin
        bv_k = k; resp = bresp; bready = 1'b1;
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
  endtask

  task automatic axi_read(
    input  logic [15:0] a,
    output logic [31:0] d,
    output logic [1:0]  resp,
    output int ar_k, output int en_k,
    output int en_n, output int rv_k);
    ar_k = -1; en_k = -1; en_n = 0; rv_k = -1;
    d = 32'hDEADBEEF; resp = 2'b11;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rready) begin
        rready = 1'b0;
        break;
      end
      if (ar_k >= 0) arvalid = 1'b0;
      if (arready && ar_k < 0) ar_k = k;
      if (en_vec != 8'h00) begin
        en_n++;
        if (en_k < 0) begin
          en_k = k; cap_en = en_vec; cap_addr = addr_data_o;
        end
      end
      if (rvalid && rv_k < 0) begin
        rv_k = k; d = rdata; resp = rresp; rready = 1'b1;
      end
    end
    arvalid = 1'b0; rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    int ak, ek, en, rk;
    rst = 1'b0;
    awvalid = 0; wvalid = 0; bready = 0;
    arvalid = 0; rready = 0; done_i = 0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({awready, wready, bvalid, arready, rvalid,
         start_o, en_vec} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0",
        {awready, wready, bvalid, arready, rvalid,
         start_o, en_vec});
    end
    n_checks++;
    if ({data_o, addr_data_o, op_o, addr_op_o,
         rdata, bresp, rresp} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0",
        {data_o, addr_data_o, op_o, addr_op_o,
         rdata, bresp, rresp});
    end
    rst = 1'b1;
    axi_read(16'h0004, d, r, ak, ek, en, rk);
    n_checks++;
    if (d !== 32'h0 || r !== RESP_OKAY || rk != 2) begin
      n_fail++;
      $display("FAIL reset_status: got %h/%0d/%0d required 0/0/2",
        d, r, rk);
    end
  endtask

  task automatic test_mem_load();
    logic [1:0] r;
    int rk, rn, ek, en, bk;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 1024; i++) begin
        axi_write(16'((pass == 0 ? 32'h1000 : 32'h2000) + 4 * i),
          32'(pass + 1), 4'hF, r, rk, rn, ek, en, bk);
        n_checks++;
        if (r !== RESP_OKAY || rk != 1 || rn != 1 ||
            ek != 2 || en != 1 || bk != 3) begin
          n_fail++;
          $display("FAIL load_timing p%0d i=%0d: got %0d %0d %0d %0d %0d %0d required 0 1 1 2 1 3",
            pass, i, r, rk, rn, ek, en, bk);
        end
        n_checks++;
        if (cap_en !== (pass == 0 ? 8'hC0 : 8'h30) ||
            cap_addr !== 10'(i) || cap_data !== 32'(pass + 1)) begin
          n_fail++;
          $display("FAIL load_strobe p%0d i=%0d: got %h/%0d/%h",
            pass, i, cap_en, cap_addr, cap_data);
        end
      end
    end
    axi_write(16'h400C, 32'h000001A5, 4'hF, r, rk, rn, ek, en, bk);
    n_checks++;
    if (r !== RESP_OKAY || cap_en !== 8'h03 ||
        cap_op !== 8'hA5 || cap_aop !== 10'd3 || en != 1) begin
      n_fail++;
      $display("FAIL op_write: got %0d/%h/%h/%0d/%0d required 0/03/a5/3/1",
        r, cap_en, cap_op, cap_aop, en);
    end
    axi_write(16'h301C, 32'h12345678, 4'hF, r, rk, rn, ek, en, bk);
    n_checks++;
    if (r !== RESP_OKAY || cap_en !== 8'h0C ||
        cap_addr !== 10'd7 || cap_data !== 32'h12345678) begin
      n_fail++;
      $display("FAIL res_write: got %0d/%h/%0d/%h required 0/0c/7/12345678",
        r, cap_en, cap_addr, cap_data);
    end
  endtask

  task automatic test_run();
    logic [1:0]  r;
    logic [31:0] d;
    int rk, rn, ek, en, bk, ak;
    axi_write(16'h0000, 32'h1, 4'hF, r, rk, rn, ek, en, bk);
    n_checks++;
    if (r !== RESP_OKAY || start_o !== 1'b1 || en != 0) begin
      n_fail++;
      $display("FAIL run_start: got %0d/%b/%0d required 0/1/0",
        r, start_o, en);
    end
    axi_read(16'h0004, d, r, ak, ek, en, rk);
    n_checks++;
    if (d !== 32'h1 || r !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL run_busy_status: got %h/%0d required 1/0", d, r);
    end
    @(negedge clk);
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    n_checks++;
    if (start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL run_done_drop: got %b required 0", start_o);
    end
    axi_read(16'h0004, d, r, ak, ek, en, rk);
    n_checks++;
    if (d !== 32'h2 || r !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL run_done_status: got %h/%0d required 2/0", d, r);
    end
    axi_read(16'h0000, d, r, ak, ek, en, rk);
    n_checks++;
    if (d !== 32'h2 || r !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL run_ctrl_read: got %h/%0d required 2/0", d, r);
    end
    axi_write(16'h0000, 32'h2, 4'hF, r, rk, rn, ek, en, bk);
    axi_read(16'h0004, d, r, ak, ek, en, rk);
    n_checks++;
    if (d !== 32'h0 || r !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL run_clear: got %h/%0d required 0/0", d, r);
    end
    @(negedge clk);
    done_i = 1'b1;
    repeat (2) @(negedge clk);
    done_i = 1'b0;
    axi_read(16'h0004, d, r, ak, ek, en, rk);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL run_idle_done: got %h required 0", d);
    end
  endtask

  task automatic test_result_read();
    logic [1:0]  r;
    logic [31:0] d;
    int ak, ek, en, rk;
    axi_read(16'h3014, d, r, ak, ek, en, rk);
    n_checks++;
    if (d !== 32'h0000ABCD || r !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL res_read_data: got %h/%0d required 0000abcd/0",
        d, r);
    end
    n_checks++;
    if (ak != 1 || ek != 2 || en != 1 || rk != 4 ||
        cap_en !== 8'h08 || cap_addr !== 10'd5) begin
      n_fail++;
      $display("FAIL res_read_timing: got %0d %0d %0d %0d %h %0d required 1 2 1 4 08 5",
        ak, ek, en, rk, cap_en, cap_addr);
    end
    axi_read(16'h301C, d, r, ak, ek, en, rk);
    n_checks++;
    if (d !== 32'h12345678 || r !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL res_readback: got %h/%0d required 12345678/0",
        d, r);
    end
  endtask

  task automatic test_busy();
    logic [1:0]  r;
    logic [31:0] d;
    int rk, rn, ek, en, bk, ak;
    axi_write(16'h0000, 32'h1, 4'hF, r, rk, rn, ek, en, bk);
    axi_write(16'h4010, 32'h7, 4'hF, r, rk, rn, ek, en, bk);
    n_checks++;
    if (r !== RESP_SLVERR || en != 0 || bk != 3) begin
      n_fail++;
      $display("FAIL busy_op_write: got %0d/%0d/%0d required 2/0/3",
        r, en, bk);
    end
    axi_read(16'h1000, d, r, ak, ek, en, rk);
    n_checks++;
    if (r !== RESP_SLVERR || d !== 32'h0 || rk != 2 || en != 0) begin
      n_fail++;
      $display("FAIL busy_a_read: got %0d/%h/%0d required 2/0/2",
        r, d, rk);
    end
    axi_write(16'h1000, 32'h5, 4'h3, r, rk, rn, ek, en, bk);
    n_checks++;
    if (r !== RESP_SLVERR || en != 0) begin
      n_fail++;
      $display("FAIL busy_strb: got %0d/%0d required 2/0", r, en);
    end
    axi_read(16'h3014, d, r, ak, ek, en, rk);
    n_checks++;
    if (r !== RESP_SLVERR || d !== 32'h0 || en != 0) begin
      n_fail++;
      $display("FAIL busy_res_read: got %0d/%h/%0d required 2/0/0",
        r, d, en);
    end
    axi_write(16'h0000, 32'h1, 4'hF, r, rk, rn, ek, en, bk);
    n_checks++;
    if (r !== RESP_OKAY || start_o !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_restart: got %0d/%b required 0/1",
        r, start_o);
    end
    @(negedge clk);
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    axi_write(16'h2000, 32'h5, 4'h3, r, rk, rn, ek, en, bk);
    n_checks++;
    if (r !== RESP_SLVERR || en != 0) begin
      n_fail++;
      $display("FAIL idle_strb: got %0d/%0d required 2/0", r, en);
    end
    axi_read(16'h5000, d, r, ak, ek, en, rk);
    n_checks++;
    if (r !== RESP_SLVERR || d !== 32'h0) begin
      n_fail++;
      $display("FAIL bad_region_read: got %0d/%h required 2/0", r, d);
    end
    axi_write(16'h0004, 32'h3, 4'hF, r, rk, rn, ek, en, bk);
    n_checks++;
    if (r !== RESP_SLVERR) begin
      n_fail++;
      $display("FAIL status_write: got %0d required 2", r);
    end
    axi_write(16'h6000, 32'h3, 4'hF, r, rk, rn, ek, en, bk);
    n_checks++;
    if (r !== RESP_SLVERR || en != 0) begin
      n_fail++;
      $display("FAIL bad_region_write: got %0d/%0d required 2/0",
        r, en);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  r;
    logic [31:0] d;
    logic [31:0] rd_seen;
    logic [1:0]  b0, r0;
    int ak, ek, en, rk;
    int ord[3];
    int ngr, wr_left, bcnt, rcnt, b_done, r_done;
    logic w_drop, r_drop, hold_bad, fin;
    axi_read(16'h0004, d, r, ak, ek, en, rk);
    n_checks++;
    if (d !== 32'h2 || r !== RESP_OKAY) begin
      n_fail++;
      $display("FAIL b2b_pre_status: got %h/%0d required 2/0", d, r);
    end
    ngr = 0; wr_left = 2; bcnt = 0; rcnt = 0;
    b_done = 0; r_done = 0; ord = '{9, 9, 9};
    w_drop = 0; r_drop = 0; hold_bad = 0; fin = 0;
    b0 = 2'b11; r0 = 2'b11; rd_seen = 32'h0;
    @(negedge clk);
    awaddr = 16'h1028; wdata = 32'h5; wstrb = 4'hF;
    araddr = 16'h3014;
    awvalid = 1; wvalid = 1; arvalid = 1;
    bready = 0; rready = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bready) bready = 0;
      if (rready) rready = 0;
      if (b_done == 2 && r_done == 1) begin
        fin = 1;
        break;
      end
      if (w_drop) begin
        awvalid = 0; wvalid = 0; w_drop = 0;
      end
      if (r_drop) begin
        arvalid = 0; r_drop = 0;
      end
      if (awready && wready) begin
        if (ngr < 3) ord[ngr] = 1;
        ngr++; w_drop = 1; wr_left--;
      end
      if (arready) begin
        if (ngr < 3) ord[ngr] = 0;
        ngr++; r_drop = 1;
      end
      if (bcnt > 0 && (!bvalid || bresp !== b0)) hold_bad = 1;
      if (bvalid) begin
        if (bcnt == 0) b0 = bresp;
        bcnt++;
        if (bcnt == 6) begin
          bready = 1; bcnt = 0; b_done++;
          if (wr_left > 0) begin
            awaddr = 16'h2028; wdata = 32'h6;
            awvalid = 1; wvalid = 1;
          end
        end
      end
      if (rcnt > 0 && (!rvalid || rdata !== rd_seen)) hold_bad = 1;
      if (rvalid) begin
        if (rcnt == 0) begin
          r0 = rresp; rd_seen = rdata;
        end
        rcnt++;
        if (rcnt == 6) begin
          rready = 1; rcnt = 0; r_done++;
        end
      end
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    bready = 0; rready = 0;
    n_checks++;
    if (!fin || ngr != 3 || ord[0] != 1 || ord[1] != 0 ||
        ord[2] != 1) begin
      n_fail++;
      $display("FAIL b2b_order: got fin=%b n=%0d %0d%0d%0d required 1 3 101",
        fin, ngr, ord[0], ord[1], ord[2]);
    end
    n_checks++;
    if (hold_bad) begin
      n_fail++;
      $display("FAIL b2b_hold: got unstable response required steady");
    end
    n_checks++;
    if (b0 !== RESP_OKAY || r0 !== RESP_OKAY ||
        rd_seen !== 32'h0000ABCD) begin
      n_fail++;
      $display("FAIL b2b_resp: got %0d/%0d/%h required 0/0/0000abcd",
        b0, r0, rd_seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0]  r;
    logic [31:0] d;
    int ak, ek, en, rk;
    logic seen, rdy, bv;
    seen = 0; rdy = 0; bv = 0;
    @(negedge clk);
    awaddr = 16'h1004; wdata = 32'h9; wstrb = 4'hF;
    awvalid = 1; wvalid = 1; bready = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rdy) begin
        awvalid = 0; wvalid = 0;
      end
      if (awready && wready) rdy = 1;
      if (en_vec != 8'h00) begin
        seen = 1; rst = 0;
        break;
      end
    end
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    n_checks++;
    if (!seen || {awready, wready, bvalid, arready, rvalid,
         start_o, en_vec} !== 14'h0 ||
        {data_o, addr_data_o, op_o, addr_op_o} !== 60'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got seen=%b %b %h required 1 0 0",
        seen, {awready, wready, bvalid, start_o, en_vec},
        {data_o, addr_data_o, op_o, addr_op_o});
    end
    rst = 1;
    bready = 0;
    repeat (4) begin
      @(negedge clk);
      if (bvalid) bv = 1;
    end
    n_checks++;
    if (bv) begin
      n_fail++;
      $display("FAIL mid_reset_bvalid: got 1 required 0");
    end
    axi_read(16'h0004, d, r, ak, ek, en, rk);
    n_checks++;
    if (d !== 32'h0 || r !== RESP_OKAY || rk != 2) begin
      n_fail++;
      $display("FAIL mid_reset_idle: got %h/%0d/%0d required 0/0/2",
        d, r, rk);
    end
  endtask

  initial begin
    test_reset();
    test_mem_load();
    test_run();
    test_result_read();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
